// File: rtl/fir_response_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_response_checker_if
// Description : Sample-pair handshake bundle between a stimulus source and
//               the FIR response checker.
//               in_valid : source has a (din, dout) pair
//               in_ready : checker can accept a pair
//               din      : filter input sample x[n]
//               dout     : DUT output captured with the same pair
//               master = pair source, slave = checker
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_response_checker_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    modport master (output in_valid, output din, output dout, input in_ready);
    modport slave  (input in_valid, input din, input dout, output in_ready);
endinterface
`default_nettype wire

// File: rtl/fir_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : fir_response_checker
// Description : Recomputes the expected direct-form FIR response for every
//               accepted (din, dout) pair using a private delay line and a
//               one-tap-per-cycle multiply-accumulate, then compares the DUT
//               output against the expected value delayed by DUT_LAT samples.
// Ports       : clk           rising-edge clock
//               rst_          asynchronous active-low reset
//               coeffs        packed taps, tap k at [DW*k +: DW]
//               s_in          pair handshake (slave side)
//               done_valid    one-cycle pulse per completed pair
//               exp_out       expected y[n], held until next completion
//               mismatch      one-cycle pulse when the compare failed
//               sample_count  pairs accepted since reset (wraps)
//               err_count     mismatches, saturating
//               first_err_idx pair index of the first mismatching dout
// Revision    : 1.0 - initial release
// ============================================================================
module fir_response_checker #(
    parameter int M       = 4,
    parameter int DW      = 32,
    parameter int DUT_LAT = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_,
    input  wire logic [(M+1)*DW-1:0]   coeffs,
    fir_response_checker_if.slave      s_in,
    output logic                       done_valid,
    output logic [DW-1:0]              exp_out,
    output logic                       mismatch,
    output logic [31:0]                sample_count,
    output logic [15:0]                err_count,
    output logic [31:0]                first_err_idx
);

    localparam int KW = (M > 0) ? $clog2(M + 1) : 1;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_MAC  = 2'd1;
    localparam state_t S_CMP  = 2'd2;

    localparam logic [15:0] c_ERR_MAX = 16'hFFFF;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [DW-1:0]   r_x [0:M];
    logic [DW-1:0]   r_acc;
    logic [DW-1:0]   r_dout;
    logic            r_in_ready;
    logic            r_done_valid;
    logic [DW-1:0]   r_exp_out;
    logic            r_mismatch;
    logic [31:0]     r_sample_count;
    logic [15:0]     r_err_count;
    logic [31:0]     r_first_err_idx;

    logic [DW-1:0]   w_coef_arr [0:M];
    logic [DW-1:0]   w_prod;
    logic [DW-1:0]   w_ref;
    logic            w_cmp_en;
    logic            w_bad;

    // Unpack the coefficient bus into a tap-indexed array.
    for (genvar g = 0; g <= M; g++) begin : g_coef
        assign w_coef_arr[g] = coeffs[DW*g +: DW];
    end

    // DW x DW product evaluated in a DW-bit context: the low DW bits are the
    // same for signed and unsigned operands, which gives the required
    // truncate-and-wrap behaviour.
    assign w_prod   = w_coef_arr[r_k] * r_x[r_k];
    assign w_cmp_en = (r_state == S_CMP);

    // Expected-value history. The entry compared is the one that would sit
    // at depth DUT_LAT after this cycle's push, i.e. the value leaving the
    // stored part of the history. With no latency the fresh result is used.
    if (DUT_LAT == 0) begin : g_hist_none
        assign w_ref = r_acc;
    end else begin : g_hist
        logic [DW-1:0] r_hist [0:DUT_LAT-1];

        assign w_ref = r_hist[DUT_LAT-1];

        always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
                for (int i = 0; i < DUT_LAT; i++) r_hist[i] <= '0;
            end else if (w_cmp_en) begin
                r_hist[0] <= r_acc;
                for (int i = 1; i < DUT_LAT; i++) r_hist[i] <= r_hist[i-1];
            end
        end
    end

    // Warm-up: the first DUT_LAT pairs carry douts with no expected value.
    assign w_bad = (r_sample_count > 32'(DUT_LAT)) && (r_dout != w_ref);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state         <= S_IDLE;
            r_k             <= '0;
            for (int i = 0; i <= M; i++) r_x[i] <= '0;
            r_acc           <= '0;
            r_dout          <= '0;
            r_in_ready      <= 1'b1;
            r_done_valid    <= 1'b0;
            r_exp_out       <= '0;
            r_mismatch      <= 1'b0;
            r_sample_count  <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
        end else begin
            r_done_valid <= 1'b0;
            r_mismatch   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (s_in.in_valid && r_in_ready) begin
                        r_x[0] <= s_in.din;
                        for (int i = 1; i <= M; i++) r_x[i] <= r_x[i-1];
                        r_dout         <= s_in.dout;
                        r_acc          <= '0;
                        r_k            <= '0;
                        r_in_ready     <= 1'b0;
                        r_sample_count <= r_sample_count + 32'd1;
                        r_state        <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_k == KW'(M)) begin
                        r_state <= S_CMP;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_CMP: begin
                    r_done_valid <= 1'b1;
                    r_exp_out    <= r_acc;
                    if (w_bad) begin
                        r_mismatch <= 1'b1;
                        if (r_err_count != c_ERR_MAX) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        // sample_count already includes this pair.
                        if (r_err_count == 16'd0) begin
                            r_first_err_idx <= r_sample_count - 32'd1;
                        end
                    end
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign s_in.in_ready = r_in_ready;
    assign done_valid    = r_done_valid;
    assign exp_out       = r_exp_out;
    assign mismatch      = r_mismatch;
    assign sample_count  = r_sample_count;
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_fir_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_response_checker
// Description : Directed bench for fir_response_checker. Two checkers run in
//               lockstep on the same din stream: one with DUT_LAT=0 fed the
//               undelayed reference response, one with DUT_LAT=1 fed the
//               response delayed by one sample (with planted faults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_response_checker;

    localparam int M  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    logic [(M+1)*DW-1:0] coeffs;

    always #5 clk = ~clk;

    fir_response_checker_if #(.DW(DW)) if0 ();
    fir_response_checker_if #(.DW(DW)) if1 ();

    logic          w_dv0, w_mm0, w_dv1, w_mm1;
    logic [31:0]   w_exp0, w_exp1, w_sc0, w_sc1, w_fe0, w_fe1;
    logic [15:0]   w_ec0, w_ec1;

    fir_response_checker #(.M(M), .DW(DW), .DUT_LAT(0)) u_dut0 (
        .clk           (clk),
        .rst_          (rst_),
        .coeffs        (coeffs),
        .s_in          (if0),
        .done_valid    (w_dv0),
        .exp_out       (w_exp0),
        .mismatch      (w_mm0),
        .sample_count  (w_sc0),
        .err_count     (w_ec0),
        .first_err_idx (w_fe0)
    );

    fir_response_checker #(.M(M), .DW(DW), .DUT_LAT(1)) u_dut1 (
        .clk           (clk),
        .rst_          (rst_),
        .coeffs        (coeffs),
        .s_in          (if1),
        .done_valid    (w_dv1),
        .exp_out       (w_exp1),
        .mismatch      (w_mm1),
        .sample_count  (w_sc1),
        .err_count     (w_ec1),
        .first_err_idx (w_fe1)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] got_exp0, got_exp1;
    logic        got_mm0, got_mm1, got_dv1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [(M+1)*DW-1:0] pack(input int c0, input int c1,
                                                 input int c2, input int c3,
                                                 input int c4);
        return {32'(c4), 32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endfunction

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [31:0] o0, input logic [31:0] o1);
        if0.in_valid = v;  if1.in_valid = v;
        if0.din      = d;  if1.din      = d;
        if0.dout     = o0; if1.dout     = o1;
    endtask

    task automatic do_reset(input logic [(M+1)*DW-1:0] c);
        @(negedge clk);
        rst_ = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        coeffs = c;
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // One pair through both checkers; results captured on the done cycle.
    task automatic send(input logic [31:0] d, input logic [31:0] o0, input logic [31:0] o1);
        int n;
        @(negedge clk);
        drive(1'b1, d, o0, o1);
        n = 0;
        while (!if0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_seen", 32'(if0.in_ready), 32'd1);
        @(negedge clk);
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        n = 0;
        while (!w_dv0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(w_dv0), 32'd1);
        got_exp0 = w_exp0;
        got_mm0  = w_mm0;
        got_exp1 = w_exp1;
        got_mm1  = w_mm1;
        got_dv1  = w_dv1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int          y_imp  [6];
        int          y_step [5];
        int          yn, prev, hs, last, dv_seen;
        logic [31:0] o1;

        y_imp  = '{-1, 2, 5, 2, -1, 0};
        y_step = '{-1, 1, 6, 8, 7};
        coeffs = pack(-1, 2, 5, 2, -1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(if0.in_ready), 32'd1);
        chk("rst_done",     32'(w_dv0), 32'd0);
        chk("rst_exp",      w_exp0, 32'd0);
        chk("rst_mismatch", 32'(w_mm0), 32'd0);
        chk("rst_count",    w_sc0, 32'd0);
        chk("rst_err",      32'(w_ec0), 32'd0);
        chk("rst_first",    w_fe0, 32'd0);
        rst_ = 1'b1;

        // Impulse response
        for (int n = 0; n < 6; n++) begin
            send((n == 0) ? 32'd1 : 32'd0, 32'(y_imp[n]),
                 (n == 0) ? 32'd0 : 32'(y_imp[n-1]));
            chk($sformatf("imp_exp0[%0d]", n), got_exp0, 32'(y_imp[n]));
            chk($sformatf("imp_mm0[%0d]", n), 32'(got_mm0), 32'd0);
            chk($sformatf("imp_exp1[%0d]", n), got_exp1, 32'(y_imp[n]));
            chk($sformatf("imp_mm1[%0d]", n), 32'(got_mm1), 32'd0);
        end
        chk("imp_err0",   32'(w_ec0), 32'd0);
        chk("imp_err1",   32'(w_ec1), 32'd0);
        chk("imp_count0", w_sc0, 32'd6);

        // Step response with faults at pairs 6 and 9 on the latency-1 checker
        do_reset(pack(-1, 2, 5, 2, -1));
        prev = 0;
        for (int n = 0; n < 50; n++) begin
            yn = (n < 5) ? y_step[n] : 7;
            o1 = 32'(prev) + (((n == 6) || (n == 9)) ? 32'd1 : 32'd0);
            send(32'd1, 32'(yn), o1);
            chk($sformatf("step_exp0[%0d]", n), got_exp0, 32'(yn));
            chk($sformatf("step_exp1[%0d]", n), got_exp1, 32'(yn));
            chk($sformatf("step_dv1[%0d]", n), 32'(got_dv1), 32'd1);
            chk($sformatf("step_mm1[%0d]", n), 32'(got_mm1),
                ((n == 6) || (n == 9)) ? 32'd1 : 32'd0);
            if (n == 6) begin
                chk("fault1_err",   32'(w_ec1), 32'd1);
                chk("fault1_first", w_fe1, 32'd6);
            end
            if (n == 9) begin
                chk("fault2_err",   32'(w_ec1), 32'd2);
                chk("fault2_first", w_fe1, 32'd6);
            end
            prev = yn;
        end
        chk("step_err0",   32'(w_ec0), 32'd0);
        chk("step_err1",   32'(w_ec1), 32'd2);
        chk("step_count1", w_sc1, 32'd50);
        chk("step_first1", w_fe1, 32'd6);

        // Wrap arithmetic: 5 * 0x7FFFFFFF mod 2^32
        do_reset(pack(5, 0, 0, 0, 0));
        send(32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'd0);
        chk("wrap_exp0", got_exp0, 32'h7FFF_FFFB);
        chk("wrap_mm0",  32'(got_mm0), 32'd0);
        chk("wrap_exp1", got_exp1, 32'h7FFF_FFFB);

        // Backpressure: in_valid held high, accepts exactly M+3 cycles apart
        do_reset(pack(5, 0, 0, 0, 0));
        drive(1'b1, 32'd0, 32'd0, 32'd0);
        hs   = 0;
        last = -1;
        for (int i = 0; i < 35; i++) begin
            if (if0.in_ready) begin
                if (last >= 0) chk($sformatf("accept_gap[%0d]", hs), 32'(i - last), 32'(M + 3));
                last = i;
                hs++;
            end
            @(negedge clk);
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        chk("bp_accepts", 32'(hs), 32'd5);
        chk("bp_count0",  w_sc0, 32'(hs));
        chk("bp_err0",    32'(w_ec0), 32'd0);

        // Asynchronous reset two cycles after a handshake
        do_reset(pack(-1, 2, 5, 2, -1));
        drive(1'b1, 32'd5, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        chk("ar_accepted", w_sc0, 32'd1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        chk("ar_in_ready", 32'(if0.in_ready), 32'd1);
        chk("ar_count",    w_sc0, 32'd0);
        chk("ar_done",     32'(w_dv0), 32'd0);
        dv_seen = 0;
        repeat (10) begin
            @(negedge clk);
            dv_seen += int'(w_dv0);
        end
        chk("ar_no_done", 32'(dv_seen), 32'd0);
        rst_ = 1'b1;
        send(32'd1, 32'hFFFF_FFFF, 32'd0);
        chk("ar_imp_exp0", got_exp0, 32'hFFFF_FFFF);
        chk("ar_imp_mm0",  32'(got_mm0), 32'd0);
        chk("ar_count_after", w_sc0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
